// File: rtl/rx_letter_buffer.sv
// rtl/rx_letter_buffer.sv - elastic letter FIFO between IR decoder and Enigma decoder
module rx_letter_buffer #(
    parameter int DATA_WIDTH    = 5,
    parameter int DEPTH         = 16,
    parameter int ERR_WIDTH     = 3,
    parameter int CNT_WIDTH     = 8,
    parameter int OVERFLOW_MODE = 0
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic [DATA_WIDTH-1:0]        code_in,
    input  logic                         new_code_in,
    input  logic [ERR_WIDTH-1:0]         error_in,
    input  logic                         flush_in,
    input  logic                         ready_in,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         data_valid_out,
    output logic [$clog2(DEPTH+1)-1:0]   count_out,
    output logic                         full_out,
    output logic                         empty_out,
    output logic [CNT_WIDTH-1:0]         overflow_count_out,
    output logic [CNT_WIDTH-1:0]         error_count_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [AW-1:0]        PTR_ONE  = AW'(1);
    localparam logic [CW-1:0]        OCC_ONE  = CW'(1);
    localparam logic [CW-1:0]        OCC_FULL = CW'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] STAT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] STAT_MAX = {CNT_WIDTH{1'b1}};
    localparam bit                   OVERWRITE = (OVERFLOW_MODE == 1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [CNT_WIDTH-1:0]  r_ovf_cnt;
    logic [CNT_WIDTH-1:0]  r_err_cnt;

    logic w_full;
    logic w_empty;
    logic w_push_req;
    logic w_err_strike;
    logic w_pop;
    logic w_write;
    logic w_overflow;
    logic w_rd_adv;

    assign w_full       = (r_count == OCC_FULL);
    assign w_empty      = (r_count == '0);
    assign w_push_req   = new_code_in && (error_in == '0);
    assign w_err_strike = new_code_in && (error_in != '0);
    assign w_pop        = !w_empty && ready_in;

    // A full buffer still accepts a code when a pop frees a slot, or always when overwriting.
    assign w_write    = w_push_req && !flush_in && (!w_full || w_pop || OVERWRITE);
    assign w_overflow = w_push_req && !flush_in && w_full && !w_pop;
    // In overwrite mode the oldest entry is sacrificed, so the read side advances too.
    assign w_rd_adv   = !flush_in && (w_pop || (w_overflow && OVERWRITE));

    // Storage array write port; contents are deliberately left unreset.
    always_ff @(posedge clk_in) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= code_in;
        end
    end

    // Pointer and occupancy bookkeeping, with flush taking priority over push/pop.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd_adv) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_write && !w_rd_adv) begin
                r_count <= r_count + OCC_ONE;
            end else if (!w_write && w_rd_adv) begin
                r_count <= r_count - OCC_ONE;
            end
        end
    end

    // Saturating debug statistics; flush leaves them alone.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_ovf_cnt <= '0;
            r_err_cnt <= '0;
        end else begin
            if (w_overflow && (r_ovf_cnt != STAT_MAX)) begin
                r_ovf_cnt <= r_ovf_cnt + STAT_ONE;
            end
            if (w_err_strike && (r_err_cnt != STAT_MAX)) begin
                r_err_cnt <= r_err_cnt + STAT_ONE;
            end
        end
    end

    assign data_out           = w_empty ? '0 : r_mem[r_rd_ptr];
    assign data_valid_out     = !w_empty;
    assign count_out          = r_count;
    assign full_out           = w_full;
    assign empty_out          = w_empty;
    assign overflow_count_out = r_ovf_cnt;
    assign error_count_out    = r_err_cnt;

endmodule

// File: doc/rx_letter_buffer.md
Name: rx_letter_buffer

Overview:
- Parametrised elastic buffer between the IR letter decoder and the Enigma decoder in the receiver path.
- Accepts single-cycle decoded-code pulses and discards codes flagged with a decoder error.
- Stores accepted codes in a circular FIFO and presents them through a valid/ready handshake, so letters that arrive while Enigma is busy are not lost.
- Adds a selectable overflow policy, a flush, and saturating drop and error statistics for the seven-segment debug display.

Parameters:
- DATA_WIDTH, 5: width of one letter code.
- DEPTH, 16: number of FIFO entries. Must be a power of two, at least 2.
- ERR_WIDTH, 3: width of the decoder error field.
- CNT_WIDTH, 8: width of the statistics counters.
- OVERFLOW_MODE, 0: 0 drops the newest code when full; 1 overwrites the oldest entry when full.

Ports:
- clk_in  input  1  system clock (100 MHz domain).
- rst_in  input  1  reset.
- code_in  input  DATA_WIDTH  decoded letter; sampled only when new_code_in=1.
- new_code_in  input  1  single-cycle strobe from the decoder.
- error_in  input  ERR_WIDTH  decoder error; non-zero marks code_in invalid.
- flush_in  input  1  synchronous clear of buffered contents.
- ready_in  input  1  consumer can take data_out this cycle.
- data_out  output  DATA_WIDTH  oldest buffered code.
- data_valid_out  output  1  data_out holds a valid code.
- count_out  output  $clog2(DEPTH+1)  current occupancy.
- full_out  output  1  occupancy == DEPTH.
- empty_out  output  1  occupancy == 0.
- overflow_count_out  output  CNT_WIDTH  codes lost to overflow, saturating.
- error_count_out  output  CNT_WIDTH  codes rejected for error, saturating.

Behaviour:
- Single clock, clk_in. Reset rst_in is asynchronous and active-high.
- While rst_in=1: both pointers=0, count_out=0, empty_out=1, full_out=0, data_valid_out=0, data_out=0, both statistics counters=0. Storage contents are not reset.
- Push request: new_code_in=1 and error_in==0.
- Error strike: new_code_in=1 and error_in!=0. No write occurs; error_count_out increments, saturating at 2^CNT_WIDTH-1.
- Pop: data_valid_out=1 and ready_in=1 in the same cycle. The read pointer advances on that clock edge.
- Output is first-word-fall-through:
  - data_out = storage[rd_ptr] when not empty, otherwise 0.
  - data_valid_out = !empty_out.
- Latency: a push accepted at edge N into an empty buffer gives data_valid_out=1 and the pushed value on data_out after edge N, i.e. 1 cycle.
- All status outputs are registered from pointers and count, and update on the same edge as the push or pop.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count tracks occupancy in 0..DEPTH.
- Simultaneous push and pop, not full: both occur and count is unchanged.
- Push while full with a pop in the same cycle: both occur (the slot is freed) and no overflow is counted, in either mode.
- Push while full without a pop:
  - OVERFLOW_MODE=0: the code is discarded; storage and pointers are unchanged; overflow_count_out increments (saturating).
  - OVERFLOW_MODE=1: the code is written at wr_ptr; wr_ptr and rd_ptr both advance; count stays DEPTH; overflow_count_out increments (saturating).
- Push into an empty buffer with ready_in=1: only the push takes effect. The code becomes visible the next cycle.
- flush_in=1 takes priority over push and pop in that cycle:
  - Pointers and count are set to 0 and data_valid_out=0 on the next cycle.
  - Any push in the same cycle is discarded and not counted as overflow.
  - Statistics counters keep their values; only rst_in clears them.
- The consumer may hold ready_in=0 indefinitely. data_out and data_valid_out stay stable until popped, flushed, or overwritten in mode 1.
- Assertion of rst_in mid-operation clears state immediately (asynchronous), regardless of clock phase.

Test Plan:
- Push codes 3, 7, 25 with ready_in=0 → count_out=3, data_out=3. Raise ready_in for 3 cycles → data_out steps 3, 7, 25; then empty_out=1, data_out=0.
- OVERFLOW_MODE=0, DEPTH=4: push 1..6 with ready_in=0 → count_out=4, full_out=1, overflow_count_out=2. Drain order is 1, 2, 3, 4.
- OVERFLOW_MODE=1, DEPTH=4: push 1..6 with ready_in=0 → overflow_count_out=2. Drain order is 3, 4, 5, 6.
- Strobe new_code_in with error_in=3'b010 and code 9 → no push, error_count_out=1, empty_out stays 1. Repeat 300 times with CNT_WIDTH=8 → error_count_out=255.
- Full buffer with push and pop in the same cycle → count_out stays DEPTH, overflow_count_out unchanged, and the new code is last in drain order. Then flush_in together with a push → count_out=0 next cycle, data_valid_out=0, counters unchanged.
- Assert rst_in asynchronously between clock edges with count_out=5 → all outputs reach reset values before the next edge. Release, push 12 → data_out=12 one cycle later.
